// File: rtl/eu_alu.sv
// Registered 16-bit ALU for an 8086-style execution unit.
// One-cycle latency; holds CF internally (in the FLAGS register) for ADC/SBB chaining.
module eu_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [5:0]  alu_control,
  input  logic        word_size,
  input  logic        fire,
  output logic [15:0] result,
  output logic [15:0] status_record,
  output logic        valid
);

  typedef enum logic [5:0] {
    OP_ADD = 6'b000000,
    OP_OR  = 6'b000010,
    OP_ADC = 6'b000100,
    OP_SBB = 6'b000110,
    OP_AND = 6'b001000,
    OP_SUB = 6'b001010,
    OP_XOR = 6'b001100,
    OP_CMP = 6'b001110,
    OP_MOV = 6'b100010
  } op_e;

  localparam logic [15:0] FLAGS_RESET = 16'hF002;

  logic [15:0] result_q, result_d;
  logic [15:0] status_q, status_d;
  logic        valid_q,  valid_d;

  logic [15:0] op_a, op_b;
  logic        cf_in;
  logic [16:0] sum, diff, alu_res;
  logic [15:0] res16, af_vec, merged, flags;
  logic        is_arith, is_sub, write_res, write_flags;
  logic        carry, a_msb, b_msb, r_msb;
  logic        cf, pf, af, zf, sf, of;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    is_arith    = 1'b0;
    is_sub      = 1'b0;
    write_res   = 1'b0;
    write_flags = 1'b0;
    alu_res     = 17'h0;

    // Byte mode works on zero-extended low bytes so carry/borrow lands in bit 8.
    op_a  = word_size ? a : {8'h00, a[7:0]};
    op_b  = word_size ? b : {8'h00, b[7:0]};
    cf_in = status_q[0];

    sum  = {1'b0, op_a} + {1'b0, op_b}
         + {16'h0000, (alu_control == OP_ADC) & cf_in};
    diff = {1'b0, op_a} - {1'b0, op_b}
         - {16'h0000, (alu_control == OP_SBB) & cf_in};

    case (alu_control)
      OP_ADD, OP_ADC: begin
        alu_res = sum;  is_arith = 1'b1;
        write_res = 1'b1; write_flags = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        alu_res = diff; is_arith = 1'b1; is_sub = 1'b1;
        write_res = 1'b1; write_flags = 1'b1;
      end
      OP_CMP: begin
        alu_res = diff; is_arith = 1'b1; is_sub = 1'b1;
        write_flags = 1'b1;
      end
      OP_OR: begin
        alu_res = {1'b0, op_a | op_b}; write_res = 1'b1; write_flags = 1'b1;
      end
      OP_AND: begin
        alu_res = {1'b0, op_a & op_b}; write_res = 1'b1; write_flags = 1'b1;
      end
      OP_XOR: begin
        alu_res = {1'b0, op_a ^ op_b}; write_res = 1'b1; write_flags = 1'b1;
      end
      OP_MOV: begin
        alu_res = {1'b0, op_b}; write_res = 1'b1;
      end
      default: ;
    endcase

    res16  = alu_res[15:0];
    carry  = word_size ? alu_res[16] : alu_res[8];
    a_msb  = word_size ? op_a[15] : op_a[7];
    b_msb  = word_size ? op_b[15] : op_b[7];
    r_msb  = word_size ? res16[15] : res16[7];
    af_vec = op_a ^ op_b ^ res16;

    cf = is_arith & carry;
    af = is_arith & af_vec[4];
    of = is_arith & (is_sub ? ((a_msb != b_msb) && (r_msb != a_msb))
                            : ((a_msb == b_msb) && (r_msb != a_msb)));
    sf = r_msb;
    zf = word_size ? (res16 == 16'h0000) : (res16[7:0] == 8'h00);
    pf = ~^res16[7:0];

    flags  = {4'hF, of, 3'b000, sf, zf, 1'b0, af, 1'b0, pf, 1'b1, cf};
    merged = word_size ? res16 : {a[15:8], res16[7:0]};

    result_d = result_q;
    status_d = status_q;
    valid_d  = fire;
    if (fire) begin
      if (write_res)   result_d = merged;
      if (write_flags) status_d = flags;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      result_q <= 16'h0000;
      status_q <= FLAGS_RESET;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
      valid_q  <= valid_d;
    end
  end

  assign result        = result_q;
  assign status_record = status_q;
  assign valid         = valid_q;

endmodule

// File: tb/tb_eu_alu.sv
// Directed self-checking bench for eu_alu: hand-computed results and FLAGS words.
module tb_eu_alu;

  logic        clk;
  logic        reset;
  logic [15:0] a, b;
  logic [5:0]  alu_control;
  logic        word_size;
  logic        fire;
  logic [15:0] result, status_record;
  logic        valid;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] ADD = 6'b000000, OR_ = 6'b000010, ADC = 6'b000100,
                         SBB = 6'b000110, AND_ = 6'b001000, SUB = 6'b001010,
                         XOR_ = 6'b001100, CMP = 6'b001110, MOV = 6'b100010,
                         BAD_OP = 6'b111111;

  eu_alu dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alu_control(alu_control),
    .word_size(word_size), .fire(fire), .result(result),
    .status_record(status_record), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one fire across a single rising edge, then sample 1 ns after it.
  task automatic do_op(input logic [5:0] op, input logic ws,
                       input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    alu_control = op; word_size = ws; a = av; b = bv; fire = 1'b1;
    @(posedge clk);
    #1 fire = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] r,
                            input logic [15:0] s, input logic v);
    check({tag, ".result"}, result, r);
    check({tag, ".status"}, status_record, s);
    check({tag, ".valid"}, {15'h0, valid}, {15'h0, v});
  endtask

  initial begin
    reset = 1'b1; fire = 1'b0; a = '0; b = '0; alu_control = '0; word_size = 1'b1;
    repeat (2) @(posedge clk);
    #1 expect_out("reset", 16'h0000, 16'hF002, 1'b0);
    @(negedge clk) reset = 1'b0;

    do_op(ADD, 1'b1, 16'h7FFF, 16'h0001);
    expect_out("add_ovf", 16'h8000, 16'hF896, 1'b1);
    @(posedge clk); #1;
    expect_out("idle_hold", 16'h8000, 16'hF896, 1'b0);

    do_op(SUB, 1'b1, 16'h0005, 16'h0005);
    expect_out("sub_zero", 16'h0000, 16'hF046, 1'b1);

    do_op(SUB, 1'b1, 16'h0000, 16'h0001);
    expect_out("sub_borrow", 16'hFFFF, 16'hF097, 1'b1);
    do_op(SBB, 1'b1, 16'h0010, 16'h0000);
    expect_out("sbb_chain", 16'h000F, 16'hF016, 1'b1);

    do_op(ADD, 1'b0, 16'h12FF, 16'h0001);
    expect_out("byte_add", 16'h1200, 16'hF057, 1'b1);
    do_op(ADC, 1'b1, 16'h0001, 16'h0001);
    expect_out("adc_cf", 16'h0003, 16'hF006, 1'b1);

    do_op(MOV, 1'b1, 16'hAAAA, 16'h1234);
    expect_out("mov", 16'h1234, 16'hF006, 1'b1);
    do_op(CMP, 1'b1, 16'h0003, 16'h0004);
    expect_out("cmp_hold", 16'h1234, 16'hF097, 1'b1);
    do_op(AND_, 1'b1, 16'hFFFF, 16'h00F0);
    expect_out("and", 16'h00F0, 16'hF006, 1'b1);
    do_op(BAD_OP, 1'b1, 16'h5555, 16'h3333);
    expect_out("undef_op", 16'h00F0, 16'hF006, 1'b1);

    do_op(OR_, 1'b0, 16'hAB00, 16'h0081);
    expect_out("byte_or", 16'hAB81, 16'hF086, 1'b1);
    do_op(SUB, 1'b0, 16'h0080, 16'h0001);
    expect_out("byte_sub_ovf", 16'h007F, 16'hF812, 1'b1);
    do_op(XOR_, 1'b1, 16'hFFFF, 16'hFFFF);
    expect_out("xor_zero", 16'h0000, 16'hF046, 1'b1);

    // Seed a non-reset state first so the reset-vs-fire check is meaningful.
    do_op(SUB, 1'b1, 16'h0000, 16'h0001);
    expect_out("pre_reset", 16'hFFFF, 16'hF097, 1'b1);
    @(negedge clk);
    reset = 1'b1; alu_control = ADD; word_size = 1'b1; a = 16'hFFFF; b = 16'h0001; fire = 1'b1;
    @(posedge clk);
    #1 fire = 1'b0;
    expect_out("reset_wins", 16'h0000, 16'hF002, 1'b0);
    @(negedge clk) reset = 1'b0;

    do_op(ADD, 1'b1, 16'hFFFF, 16'h0001);
    expect_out("post_reset_add", 16'h0000, 16'hF057, 1'b1);
    @(posedge clk); #1;
    check("final_valid_drop", {15'h0, valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/eu_alu.md
# eu_alu

Registered 16-bit arithmetic/logic unit for the 8086-style execution unit. Each cycle it samples two operands, a 6-bit opcode (instruction bits [15:10]) and a fire strobe. It produces a result and an 8086-layout FLAGS word one clock later. It sits between the register file read ports and the write-back path, and holds the carry flag internally for ADC/SBB chaining.

## Interface
- No parameters; data width fixed at 16 bits.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; dominates every other input.
- a  input  16  destination/first operand.
- b  input  16  source/second operand.
- alu_control  input  6  opcode, equal to instruction[15:10].
- word_size  input  1  1 = 16-bit operation, 0 = byte operation on [7:0].
- fire  input  1  execute request, sampled on rising edge.
- result  output  16  registered result.
- status_record  output  16  registered FLAGS word.
- valid  output  1  one-cycle pulse: result/status_record updated by the previous fire.

## Operation
- Opcodes:
  - 000000 ADD: a+b.
  - 000010 OR.
  - 000100 ADC: a+b+CF.
  - 000110 SBB: a-b-CF.
  - 001000 AND.
  - 001010 SUB: a-b.
  - 001100 XOR.
  - 001110 CMP: flags as SUB; result register not written.
  - 100010 MOV: result=b; flags unchanged.
  - Any other opcode: result and flags unchanged; valid still pulses.
- Word mode:
  - Full 16-bit operation.
  - CF = carry out of bit 15 (add) or borrow (subtract).
  - OF = signed overflow at bit 15.
  - SF = bit 15; ZF = all 16 bits zero.
- Byte mode:
  - Operates on a[7:0], b[7:0].
  - result = {a[15:8], byte_result}.
  - CF/OF/SF from bit 7; ZF from low byte only.
- PF = 1 when result[7:0] has an even number of ones, in both modes.
- AF = carry/borrow out of bit 3 for arithmetic ops; 0 for logic ops.
- Logic ops (OR/AND/XOR): CF=0, OF=0, AF=0; SF/ZF/PF from result.
- FLAGS layout:
  - bit0 CF, bit2 PF, bit4 AF, bit6 ZF, bit7 SF, bit11 OF.
  - bits 15:12 = 1 and bit1 = 1 (constant).
  - bits 3, 5, 8, 9, 10 = 0.
- CF used by ADC/SBB is status_record[0] as registered before the current fire.
- Back-to-back fires allowed every cycle; each uses the flags from the prior completed operation.

## Timing
- Reset values: result=16'h0000, status_record=16'hF002, valid=0.
- Latency: fire high at edge N → result/status_record/valid updated at edge N (visible after it); valid deasserts at edge N+1 unless fire is high again.
- fire low: outputs hold; valid=0.
- Operands and opcode need only be stable around the sampling edge; no combinational path from inputs to outputs.
- Reset coinciding with fire: reset wins; the operation is discarded.
- Arithmetic wraps modulo 2^16 (word) or 2^8 (byte); no saturation.

## Test plan
- Word ADD, a=7FFF, b=0001, fire → result 8000, status F896 (OF, SF, AF, PF), valid one cycle.
- Word SUB, a=0005, b=0005 → result 0000, status F046 (ZF, PF).
- Word SUB, a=0000, b=0001 → result FFFF, status F097 (CF, SF, AF, PF). Next cycle SBB, a=0010, b=0000 → result 000F, status F016.
- Byte ADD (word_size=0), a=12FF, b=0001 → result 1200, status F057 (CF, ZF, AF, PF).
- Result-hold cases:
  - Prior result 1234, CMP a=0003, b=0004 → result stays 1234, status F097.
  - AND a=FFFF, b=00F0 → result 00F0, status F006 (PF), CF cleared.
- Reset asserted in the same cycle as fire with ADD FFFF+0001 → result 0000, status F002, valid 0. Fire with reset low → normal operation resumes.
